audio_sample_reader: RTL and testbench

AUDIO_SAMPLE_READER -- requirements
Module: audio_sample_reader

---
 rtl/heartaware_audio_pkg.sv | 14 +
 rtl/sample_tick_gen.sv | 39 +++
 rtl/audio_sample_reader.sv | 144 ++++++++++++++
 tb/tb_audio_sample_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/heartaware_audio_pkg.sv
// Shared audio definitions: playback FSM state encoding and reader defaults.
package heartaware_audio_pkg;

    localparam int unsigned SAMPLE_DIV_DEFAULT = 2083;
    localparam logic [7:0]  IDLE_LEVEL_DEFAULT = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FETCH = 2'd2,
        LATCH = 2'd3
    } reader_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator: one-cycle tick every SAMPLE_DIV clocks while enabled,
// counter parked at zero while disabled.
module sample_tick_gen
    import heartaware_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(SAMPLE_DIV - 1);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!enable) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/audio_sample_reader.sv
// Pops one byte per sample period from the audio FIFO and presents it to the PWM.
// Optional macro AUDIO_SAMPLE_READER_VOLUME_EN adds a volume_shift attenuator.
module audio_sample_reader
    import heartaware_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
    parameter logic [7:0]  IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  sample_out,
    output logic        sample_strobe,
    input  logic        underrun_clr,
`ifdef AUDIO_SAMPLE_READER_VOLUME_EN
    input  logic [2:0]  volume_shift,
`endif
    output logic        underrun,
    output logic [15:0] underrun_count
);

    reader_state_e state_q, state_d;
    logic          pend_q, pend_d;
    logic [7:0]    sample_out_q, sample_out_d;
    logic          strobe_q, strobe_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   underrun_count_q, underrun_count_d;
    logic          tick;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .tick  (tick)
    );

`ifdef AUDIO_SAMPLE_READER_VOLUME_EN
    // Attenuate around mid-scale, then clamp back into the unsigned PWM range.
    function automatic logic [7:0] scale_sample(input logic [7:0] din, input logic [2:0] shift);
        logic signed [8:0] diff;
        logic signed [9:0] sum;
        diff = $signed({1'b0, din}) - $signed({1'b0, IDLE_LEVEL});
        diff = diff >>> shift;
        sum  = $signed({diff[8], diff}) + $signed({2'b00, IDLE_LEVEL});
        if (sum < 10'sd0) begin
            return 8'h00;
        end else if (sum > 10'sd255) begin
            return 8'hFF;
        end
        return sum[7:0];
    endfunction
`endif

    always_comb begin
        state_d          = state_q;
        pend_d           = pend_q;
        sample_out_d     = sample_out_q;
        strobe_d         = 1'b0;
        underrun_d       = underrun_q;
        underrun_count_d = underrun_count_q;
        fifo_rd_en       = 1'b0;

        if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                sample_out_d = IDLE_LEVEL;
                if (enable) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_d      = IDLE;
                    sample_out_d = IDLE_LEVEL;
                end else if (tick) begin
                    state_d = FETCH;
                    // An empty tick still walks FETCH/LATCH so its idle sample lands on the same slot timing.
                    if (fifo_empty) begin
                        pend_d     = 1'b1;
                        underrun_d = 1'b1;
                    end else begin
                        pend_d     = 1'b0;
                        fifo_rd_en = 1'b1;
                    end
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                strobe_d = 1'b1;
                if (pend_q) begin
                    sample_out_d = IDLE_LEVEL;
                    underrun_d   = 1'b1;
                    if (underrun_count_q != 16'hFFFF) begin
                        underrun_count_d = underrun_count_q + 16'd1;
                    end
                end else begin
`ifdef AUDIO_SAMPLE_READER_VOLUME_EN
                    sample_out_d = scale_sample(fifo_dout, volume_shift);
`else
                    sample_out_d = fifo_dout;
`endif
                end
                state_d = enable ? WAIT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            pend_q           <= 1'b0;
            sample_out_q     <= IDLE_LEVEL;
            strobe_q         <= 1'b0;
            underrun_q       <= 1'b0;
            underrun_count_q <= '0;
        end else begin
            state_q          <= state_d;
            pend_q           <= pend_d;
            sample_out_q     <= sample_out_d;
            strobe_q         <= strobe_d;
            underrun_q       <= underrun_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    assign sample_out     = sample_out_q;
    assign sample_strobe  = strobe_q;
    assign underrun       = underrun_q;
    assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_audio_sample_reader.sv
// Directed bench for audio_sample_reader with SAMPLE_DIV=8 and a behavioural FIFO.
module tb_audio_sample_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  sample_out;
    logic        sample_strobe;
    logic        underrun_clr = 1'b0;
    logic        underrun;
    logic [15:0] underrun_count;
`ifdef AUDIO_SAMPLE_READER_VOLUME_EN
    logic [2:0]  volume_shift = 3'd0;
`endif

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic [7:0] mem [0:63];
    int push_cnt   = 0;
    int pop_cnt    = 0;
    int strobe_cnt = 0;
    int bad_pop    = 0;
    int pop_snap;
    int strobe_snap;

    always #5 clk = ~clk;

    assign fifo_empty = (push_cnt == pop_cnt);

    audio_sample_reader #(
        .SAMPLE_DIV(8),
        .IDLE_LEVEL(8'h80)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe),
        .underrun_clr  (underrun_clr),
`ifdef AUDIO_SAMPLE_READER_VOLUME_EN
        .volume_shift  (volume_shift),
`endif
        .underrun      (underrun),
        .underrun_count(underrun_count)
    );

    // Behavioural FIFO: registered read data, one cycle after the pop strobe.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[pop_cnt[5:0]];
            pop_cnt   <= pop_cnt + 1;
        end
        if (fifo_rd_en && fifo_empty) bad_pop <= bad_pop + 1;
        if (sample_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[push_cnt[5:0]] = b;
        push_cnt++;
    endtask

    task automatic wait_to(input int target);
        while (n < target) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic start_enable();
        n = 0;
        enable = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sample_out", 32'(sample_out), 32'h80);
        check("rst_strobe", 32'(sample_strobe), 32'h0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        check("rst_count", 32'(underrun_count), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Normal playback of three preloaded bytes
        push(8'h10); push(8'h20); push(8'h30);
        strobe_snap = strobe_cnt;
        start_enable();
        wait_to(6);  check("t1_no_pop_early", 32'(fifo_rd_en), 32'h0);
        wait_to(7);  check("t1_pop1", 32'(fifo_rd_en), 32'h1);
        wait_to(8);  check("t1_pop1_single", 32'(fifo_rd_en), 32'h0);
        wait_to(9);  check("t1_pre_latch_out", 32'(sample_out), 32'h80);
                     check("t1_pre_latch_strobe", 32'(sample_strobe), 32'h0);
        wait_to(10); check("t1_s1_out", 32'(sample_out), 32'h10);
                     check("t1_s1_strobe", 32'(sample_strobe), 32'h1);
        wait_to(11); check("t1_s1_strobe_end", 32'(sample_strobe), 32'h0);
                     check("t1_s1_hold", 32'(sample_out), 32'h10);
        wait_to(15); check("t1_pop2", 32'(fifo_rd_en), 32'h1);
        wait_to(18); check("t1_s2_out", 32'(sample_out), 32'h20);
        wait_to(23); check("t1_pop3", 32'(fifo_rd_en), 32'h1);
        wait_to(26); check("t1_s3_out", 32'(sample_out), 32'h30);
        wait_to(27); check("t1_strobes", 32'(strobe_cnt - strobe_snap), 32'd3);
                     check("t1_no_underrun", 32'(underrun), 32'h0);
        wait_to(28); enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Underrun on an empty FIFO for 40 enabled cycles
        pop_snap = pop_cnt;
        strobe_snap = strobe_cnt;
        start_enable();
        wait_to(10); check("t2_first_out", 32'(sample_out), 32'h80);
                     check("t2_first_strobe", 32'(sample_strobe), 32'h1);
                     check("t2_first_count", 32'(underrun_count), 32'd1);
        wait_to(40); enable = 1'b0;
        wait_to(44); check("t2_underrun", 32'(underrun), 32'h1);
                     check("t2_count", 32'(underrun_count), 32'd5);
                     check("t2_strobes", 32'(strobe_cnt - strobe_snap), 32'd5);
                     check("t2_out", 32'(sample_out), 32'h80);
                     check("t2_no_pops", 32'(pop_cnt - pop_snap), 32'd0);

        // Enable dropped during FETCH
        pop_snap = pop_cnt;
        push(8'hAA);
        start_enable();
        wait_to(7);  check("t3_pop", 32'(fifo_rd_en), 32'h1);
        wait_to(8);  enable = 1'b0;
        wait_to(10); check("t3_latched", 32'(sample_out), 32'hAA);
                     check("t3_strobe", 32'(sample_strobe), 32'h1);
        wait_to(11); check("t3_idle_out", 32'(sample_out), 32'h80);
                     check("t3_idle_strobe", 32'(sample_strobe), 32'h0);
        push(8'hBB);
        wait_to(31); check("t3_no_more_pops", 32'(pop_cnt - pop_snap), 32'd1);
                     check("t3_bb_kept", 32'(fifo_empty), 32'h0);

        // Saturation and clear priority
        push_cnt = pop_cnt;
        start_enable();
        wait_to(1);  force dut.underrun_count_q = 16'hFFFE;
        wait_to(2);  release dut.underrun_count_q;
        wait_to(10); check("t4_sat1", 32'(underrun_count), 32'hFFFF);
        wait_to(18); check("t4_sat2", 32'(underrun_count), 32'hFFFF);
        wait_to(26); check("t4_sat3", 32'(underrun_count), 32'hFFFF);
        wait_to(28); underrun_clr = 1'b1;
        wait_to(29); underrun_clr = 1'b0;
                     check("t4_clr", 32'(underrun), 32'h0);
        wait_to(31); underrun_clr = 1'b1;
        wait_to(32); underrun_clr = 1'b0;
                     check("t4_set_wins", 32'(underrun), 32'h1);
        wait_to(34); check("t4_sat4", 32'(underrun_count), 32'hFFFF);
        wait_to(36); enable = 1'b0;
        wait_to(38);

        // Reset asserted during FETCH
        push(8'h55);
        start_enable();
        wait_to(7);  check("t5_pop", 32'(fifo_rd_en), 32'h1);
        wait_to(8);
        reset = 1'b1;
        enable = 1'b0;
        #1;
        check("t5_rst_out", 32'(sample_out), 32'h80);
        check("t5_rst_strobe", 32'(sample_strobe), 32'h0);
        check("t5_rst_rd_en", 32'(fifo_rd_en), 32'h0);
        check("t5_rst_underrun", 32'(underrun), 32'h0);
        check("t5_rst_count", 32'(underrun_count), 32'h0);
        wait_to(9);
        reset = 1'b0;
        pop_snap = pop_cnt;
        strobe_snap = strobe_cnt;
        wait_to(17);
        check("t5_no_pop_after", 32'(pop_cnt - pop_snap), 32'd0);
        check("t5_no_strobe_after", 32'(strobe_cnt - strobe_snap), 32'd0);
        check("t5_out_idle", 32'(sample_out), 32'h80);

`ifdef AUDIO_SAMPLE_READER_VOLUME_EN
        // Volume attenuation around mid-scale
        push(8'hF0); push(8'h00);
        volume_shift = 3'd1;
        start_enable();
        wait_to(10); check("vol_f0_sh1", 32'(sample_out), 32'hB8);
        volume_shift = 3'd2;
        wait_to(18); check("vol_00_sh2", 32'(sample_out), 32'h60);
        enable = 1'b0;
        repeat (4) @(negedge clk);
`endif

        check("no_pop_when_empty", 32'(bad_pop), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
